multi_pattern_generator: RTL and testbench

Parametrised, multi-mode debug pattern source that streams 17-bit command/pixel words into the LCD-side FIFO. It uses the same word protocol as the camera path: frame start, row start, RGB565 pixels, frame end. It extends the single colour-bar generator with selectable patterns, frame-animated content, a frame limit, inter-frame gaps and lossless backpressure. It sits in the framebuffer clock domain, ahead of the dual-clock LCD queue.

---
 rtl/multi_pattern_generator_pkg.sv | 34 +++
 rtl/multi_pattern_generator_pixel_calc.sv | 50 +++++
 rtl/multi_pattern_generator.sv | 239 +++++++++++++++++++++++
 tb/tb_multi_pattern_generator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_pattern_generator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_gen_pkg
//  Description : Shared word encodings, colour palette and pattern-mode enum
//                for the multi-mode LCD debug pattern source.
//  Revision    : 1.0 - initial release
// ============================================================================
package pattern_gen_pkg;

    // Command words share the 17-bit stream with pixels; bit 16 marks a command.
    localparam logic [16:0] CMD_FRAME_START = 17'h10000;
    localparam logic [16:0] CMD_ROW_START   = 17'h10001;
    localparam logic [16:0] CMD_FRAME_END   = 17'h1FFFF;

    // RGB565 palette, entry 0 is the rightmost element of the concatenation.
    localparam logic [7:0][15:0] PALETTE = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

    typedef enum logic [1:0] {
        PM_BARS     = 2'd0,
        PM_GRADIENT = 2'd1,
        PM_CHECKER  = 2'd2,
        PM_SOLID    = 2'd3
    } pattern_mode_t;

    // Counter width helper that never returns zero for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_pattern_generator_pixel_calc.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_pixel_calc
//  Description : Combinational RGB565 pixel generator for the four debug
//                patterns. The bar index arrives precomputed from a per-bar
//                column counter so no divider is needed here.
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_pixel_calc
    import pattern_gen_pkg::*;
#(
    parameter int COL_W         = 9,
    parameter int ROW_W         = 9,
    parameter int BAR_W         = 4,
    parameter int CHECKER_SHIFT = 4
) (
    input  pattern_mode_t    mode,
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    input  logic [4:0]       fc,
    input  logic [BAR_W-1:0] bar_idx,
    output logic [15:0]      pixel
);

    logic [2:0] w_bar_sel;
    logic [2:0] w_solid_sel;
    logic       w_tile_odd;
    logic       w_checker_on;

    // Bar colours wrap through the 8-entry palette.
    assign w_bar_sel    = 3'(bar_idx);
    assign w_solid_sel  = fc[2:0];
    // Tile parity: low bit of the tile coordinates differs, then flipped every frame.
    assign w_tile_odd   = (((32'(col) >> CHECKER_SHIFT) & 32'd1) != ((32'(row) >> CHECKER_SHIFT) & 32'd1));
    assign w_checker_on = w_tile_odd ^ fc[0];

    // Select the pattern pixel for the current coordinate.
    always_comb begin
        pixel = 16'h0000;
        case (mode)
            PM_BARS:     pixel = PALETTE[w_bar_sel];
            PM_GRADIENT: pixel = {5'(col), 6'(row), fc};
            PM_CHECKER:  pixel = w_checker_on ? 16'hFFFF : 16'h0000;
            PM_SOLID:    pixel = PALETTE[w_solid_sel];
            default:     pixel = 16'h0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_pattern_generator.sv
`default_nettype none
// ============================================================================
//  Module      : multi_pattern_generator
//  Description : Multi-mode debug pattern source streaming 17-bit command /
//                RGB565 words into the LCD-side FIFO, with frame limit,
//                inter-frame gap and lossless backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_pattern_generator
    import pattern_gen_pkg::*;
#(
    parameter int FRAME_WIDTH    = 480,
    parameter int FRAME_HEIGHT   = 272,
    parameter int NUM_COLOR_BARS = 10,
    parameter int CHECKER_SHIFT  = 4,
    parameter int FRAME_GAP      = 16,
    parameter int FRAME_LIMIT    = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic        queue_full,
    output logic [16:0] queue_data,
    output logic        queue_wr_en,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam int c_col_w     = clog2_min1(FRAME_WIDTH);
    localparam int c_row_w     = clog2_min1(FRAME_HEIGHT);
    localparam int c_bar_w     = clog2_min1(NUM_COLOR_BARS);
    localparam int c_gap_w     = clog2_min1(FRAME_GAP + 1);
    localparam int c_bar_width = FRAME_WIDTH / NUM_COLOR_BARS;

    localparam logic [c_col_w-1:0] c_last_col     = c_col_w'(FRAME_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_last_row     = c_row_w'(FRAME_HEIGHT - 1);
    localparam logic [c_bar_w-1:0] c_last_bar     = c_bar_w'(NUM_COLOR_BARS - 1);
    localparam logic [c_col_w-1:0] c_bar_last_col = c_col_w'(c_bar_width - 1);
    localparam logic [c_gap_w-1:0] c_gap_end      = c_gap_w'(FRAME_GAP);

    localparam logic [2:0] c_st_idle        = 3'd0;
    localparam logic [2:0] c_st_frame_start = 3'd1;
    localparam logic [2:0] c_st_row_start   = 3'd2;
    localparam logic [2:0] c_st_pixels      = 3'd3;
    localparam logic [2:0] c_st_frame_end   = 3'd4;
    localparam logic [2:0] c_st_gap         = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic               r_word_valid;
    logic               w_fire;
    logic               w_slot;
    logic               w_load;
    logic               w_gen_valid;
    logic [16:0]        w_gen_word;
    logic [15:0]        w_pixel;
    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic [c_bar_w-1:0] r_bar_idx;
    logic [c_col_w-1:0] r_bar_col;
    logic [c_gap_w-1:0] r_gap_cnt;
    logic [15:0]        r_limit_cnt;
    pattern_mode_t      r_mode;
    logic [4:0]         r_fc;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_limit_ok;
    logic               w_gap_done;
    logic               w_fe_write;

    // The output register is the only storage stage: a new word may enter
    // when it is empty or its current word is being written this cycle.
    assign w_fire      = r_word_valid && !queue_full;
    assign w_slot      = !r_word_valid || w_fire;
    assign w_load      = w_gen_valid && w_slot;
    assign queue_wr_en = w_fire;

    assign w_last_col  = (r_col == c_last_col);
    assign w_last_row  = (r_row == c_last_row);
    assign w_gap_done  = (r_gap_cnt == c_gap_end);
    assign w_limit_ok  = (FRAME_LIMIT == 0) || (r_limit_cnt < 16'(FRAME_LIMIT));
    // Pixels never set bit 16, so this word value uniquely marks a frame end.
    assign w_fe_write  = w_fire && (queue_data == CMD_FRAME_END);

    pattern_pixel_calc #(
        .COL_W        (c_col_w),
        .ROW_W        (c_row_w),
        .BAR_W        (c_bar_w),
        .CHECKER_SHIFT(CHECKER_SHIFT)
    ) u_pixel_calc (
        .mode   (r_mode),
        .col    (r_col),
        .row    (r_row),
        .fc     (r_fc),
        .bar_idx(r_bar_idx),
        .pixel  (w_pixel)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: each word-producing state advances once its word is accepted.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (enable && w_limit_ok) w_next_state = c_st_frame_start;
            end
            c_st_frame_start: begin
                if (w_slot) w_next_state = c_st_row_start;
            end
            c_st_row_start: begin
                if (w_slot) w_next_state = c_st_pixels;
            end
            c_st_pixels: begin
                if (w_slot && w_last_col) w_next_state = w_last_row ? c_st_frame_end : c_st_row_start;
            end
            c_st_frame_end: begin
                if (w_slot) w_next_state = c_st_gap;
            end
            c_st_gap: begin
                // Gap counting only starts once the frame-end word has left.
                if (!r_word_valid && w_gap_done) w_next_state = (enable && w_limit_ok) ? c_st_frame_start : c_st_idle;
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // Output decode: word offered by the current state.
    always_comb begin
        w_gen_valid = 1'b0;
        w_gen_word  = 17'h00000;
        case (r_state)
            c_st_frame_start: begin w_gen_valid = 1'b1; w_gen_word = CMD_FRAME_START; end
            c_st_row_start:   begin w_gen_valid = 1'b1; w_gen_word = CMD_ROW_START;   end
            c_st_pixels:      begin w_gen_valid = 1'b1; w_gen_word = {1'b0, w_pixel}; end
            c_st_frame_end:   begin w_gen_valid = 1'b1; w_gen_word = CMD_FRAME_END;   end
            default:          begin w_gen_valid = 1'b0; w_gen_word = 17'h00000;       end
        endcase
    end

    assign busy = (r_state != c_st_idle);

    // Output register: hold the word stable until the FIFO accepts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            queue_data   <= 17'h00000;
            r_word_valid <= 1'b0;
        end else if (w_load) begin
            queue_data   <= w_gen_word;
            r_word_valid <= 1'b1;
        end else if (w_fire) begin
            r_word_valid <= 1'b0;
        end
    end

    // Position, bar, gap counters and per-frame latches advance as words are accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_bar_idx <= '0;
            r_bar_col <= '0;
            r_gap_cnt <= '0;
            r_mode    <= PM_BARS;
            r_fc      <= '0;
        end else begin
            case (r_state)
                c_st_frame_start: begin
                    if (w_slot) begin
                        r_mode <= pattern_mode_t'(mode);
                        r_fc   <= frame_count[4:0];
                        r_row  <= '0;
                    end
                end
                c_st_row_start: begin
                    if (w_slot) begin
                        r_col     <= '0;
                        r_bar_idx <= '0;
                        r_bar_col <= '0;
                    end
                end
                c_st_pixels: begin
                    if (w_slot) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            if (!w_last_row) r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        // The last bar stops counting so it absorbs the remainder columns.
                        if (r_bar_idx != c_last_bar) begin
                            if (r_bar_col == c_bar_last_col) begin
                                r_bar_idx <= r_bar_idx + 1'b1;
                                r_bar_col <= '0;
                            end else begin
                                r_bar_col <= r_bar_col + 1'b1;
                            end
                        end
                    end
                end
                c_st_frame_end: begin
                    if (w_slot) r_gap_cnt <= '0;
                end
                c_st_gap: begin
                    if (!r_word_valid && !w_gap_done) r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Frame accounting on the frame-end write; limit re-arms while idle and disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done  <= 1'b0;
            frame_count <= 16'h0000;
            r_limit_cnt <= 16'h0000;
        end else begin
            frame_done <= w_fe_write;
            if (w_fe_write) begin
                frame_count <= frame_count + 16'd1;
                if (FRAME_LIMIT != 0) r_limit_cnt <= r_limit_cnt + 16'd1;
            end else if ((r_state == c_st_idle) && !enable) begin
                r_limit_cnt <= 16'h0000;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_pattern_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_pattern_generator
//  Description : Self-checking bench with three generator configurations:
//                wide bars frame, random-backpressure stream against a
//                reference model, and checker/limit/gap behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_pattern_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pal(input int i);
        case (i % 8)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Pixel value straight from the pattern definitions.
    function automatic logic [15:0] ref_pixel(input int m, input int col, input int row, input int fc,
                                              input int w, input int nb, input int sh);
        int idx;
        case (m)
            0: begin
                idx = col / (w / nb);
                if (idx > nb - 1) idx = nb - 1;
                return pal(idx);
            end
            1: return 16'(((col & 31) << 11) | ((row & 63) << 5) | (fc & 31));
            2: return ((((col >> sh) ^ (row >> sh) ^ fc) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: return pal(fc % 8);
        endcase
    endfunction

    // ---------------- DUT A: 480-wide bars, 2 rows, single frame ----------------
    logic a_rst_n = 1'b0, a_en = 1'b0, a_full = 1'b0;
    logic [1:0] a_mode = 2'd0;
    logic [16:0] a_data;
    logic a_wr, a_done, a_busy;
    logic [15:0] a_count;
    logic [16:0] a_q[$];
    int a_done_cnt = 0;

    multi_pattern_generator #(.FRAME_WIDTH(480), .FRAME_HEIGHT(2), .NUM_COLOR_BARS(10),
        .CHECKER_SHIFT(4), .FRAME_GAP(2), .FRAME_LIMIT(1)) u_dut_a (
        .clk(clk), .reset_n(a_rst_n), .enable(a_en), .mode(a_mode), .queue_full(a_full),
        .queue_data(a_data), .queue_wr_en(a_wr), .frame_done(a_done),
        .frame_count(a_count), .busy(a_busy));

    always @(negedge clk) begin
        if (a_wr) a_q.push_back(a_data);
        if (a_done) a_done_cnt++;
    end

    // ---------------- DUT B: 8x4, random backpressure, model-checked ----------------
    logic b_rst_n = 1'b0, b_en = 1'b0, b_full = 1'b0;
    logic [1:0] b_mode = 2'd0;
    logic [16:0] b_data;
    logic b_wr, b_done, b_busy;
    logic [15:0] b_count;
    logic [16:0] b_exp[$];
    logic [16:0] b_word;
    int b_fc_model = 0;
    int b_viol = 0;
    bit b_in_frame = 1'b0;
    bit b_sb_en = 1'b0;

    multi_pattern_generator #(.FRAME_WIDTH(8), .FRAME_HEIGHT(4), .NUM_COLOR_BARS(3),
        .CHECKER_SHIFT(1), .FRAME_GAP(1), .FRAME_LIMIT(0)) u_dut_b (
        .clk(clk), .reset_n(b_rst_n), .enable(b_en), .mode(b_mode), .queue_full(b_full),
        .queue_data(b_data), .queue_wr_en(b_wr), .frame_done(b_done),
        .frame_count(b_count), .busy(b_busy));

    // Scoreboard: each new frame is predicted in full from the mode in effect at its start.
    always @(negedge clk) begin
        if (b_wr && b_full) b_viol++;
        if (b_sb_en && b_wr) begin
            if (b_exp.size() == 0) begin
                check("b_frame_start", 32'(b_data), 32'h10000);
                b_in_frame = 1'b1;
                for (int r = 0; r < 4; r++) begin
                    b_exp.push_back(17'h10001);
                    for (int c = 0; c < 8; c++)
                        b_exp.push_back({1'b0, ref_pixel(int'(b_mode), c, r, b_fc_model, 8, 3, 1)});
                end
                b_exp.push_back(17'h1FFFF);
                b_fc_model++;
            end else begin
                b_word = b_exp.pop_front();
                check("b_word", 32'(b_data), 32'(b_word));
                if (b_word == 17'h1FFFF) b_in_frame = 1'b0;
            end
        end
        if (b_sb_en && b_done) check("b_frame_count", 32'(b_count), 32'(b_fc_model));
    end

    // ---------------- DUT C: 8x8 checker, limit 2, gap 3 ----------------
    logic c_rst_n = 1'b0, c_en = 1'b0, c_full = 1'b0;
    logic [1:0] c_mode = 2'd2;
    logic [16:0] c_data;
    logic c_wr, c_done, c_busy;
    logic [15:0] c_count;
    logic [16:0] c_q[$];
    int c_done_cnt = 0, c_fs_cnt = 0, c_fe_cyc = -1, c_gap_min = 1000, cyc = 0;

    multi_pattern_generator #(.FRAME_WIDTH(8), .FRAME_HEIGHT(8), .NUM_COLOR_BARS(2),
        .CHECKER_SHIFT(2), .FRAME_GAP(3), .FRAME_LIMIT(2)) u_dut_c (
        .clk(clk), .reset_n(c_rst_n), .enable(c_en), .mode(c_mode), .queue_full(c_full),
        .queue_data(c_data), .queue_wr_en(c_wr), .frame_done(c_done),
        .frame_count(c_count), .busy(c_busy));

    always @(negedge clk) begin
        cyc++;
        if (c_wr) begin
            c_q.push_back(c_data);
            if (c_data == 17'h10000) begin
                c_fs_cnt++;
                if (c_fe_cyc >= 0 && (cyc - c_fe_cyc - 1) < c_gap_min) c_gap_min = cyc - c_fe_cyc - 1;
            end
            if (c_data == 17'h1FFFF) c_fe_cyc = cyc;
        end
        if (c_done) c_done_cnt++;
    end

    typedef struct {
        string       name;
        int          idx;
        logic [16:0] exp;
    } word_vec_t;

    word_vec_t a_vec[8];
    word_vec_t c_vec[8];

    int lat;

    initial begin
        // Frame layout: FS at 0, row r start at 1+r*(W+1), pixel (c,r) at 2+r*(W+1)+c.
        a_vec[0] = '{"a_word0",    0,   17'h10000};
        a_vec[1] = '{"a_word1",    1,   17'h10001};
        a_vec[2] = '{"a_col47",    49,  17'h0FFFF};
        a_vec[3] = '{"a_col48",    50,  17'h0FFE0};
        a_vec[4] = '{"a_col479",   481, 17'h0FFE0};
        a_vec[5] = '{"a_row1",     482, 17'h10001};
        a_vec[6] = '{"a_r1_col0",  483, 17'h0FFFF};
        a_vec[7] = '{"a_last",     963, 17'h1FFFF};
        // C frames are 74 words; frame f pixel (c,r) at f*74 + 2 + r*9 + c.
        c_vec[0] = '{"c_f0_0_0", 2,            17'h00000};
        c_vec[1] = '{"c_f0_4_0", 6,            17'h0FFFF};
        c_vec[2] = '{"c_f0_0_4", 2 + 36,       17'h0FFFF};
        c_vec[3] = '{"c_f0_4_4", 2 + 36 + 4,   17'h00000};
        c_vec[4] = '{"c_f0_3_7", 2 + 63 + 3,   17'h0FFFF};
        c_vec[5] = '{"c_f1_0_0", 74 + 2,       17'h0FFFF};
        c_vec[6] = '{"c_f1_4_0", 74 + 6,       17'h00000};
        c_vec[7] = '{"c_f1_7_7", 74 + 2 + 70,  17'h0FFFF};

        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  32'(a_data),  32'h0);
        check("rst_wr",    32'(a_wr),    32'h0);
        check("rst_done",  32'(a_done),  32'h0);
        check("rst_count", 32'(a_count), 32'h0);
        check("rst_busy",  32'(a_busy),  32'h0);
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

        // ---- A: one wide bars frame ----
        @(posedge clk); #1;
        a_en = 1'b1;
        for (int i = 0; i < 3000 && a_done_cnt < 1; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("a_done_pulses", 32'(a_done_cnt), 32'd1);
        check("a_word_total",  32'(a_q.size()), 32'd964);
        check("a_count",       32'(a_count),    32'd1);
        check("a_busy_end",    32'(a_busy),     32'd0);
        for (int i = 0; i < 8; i++)
            check(a_vec[i].name, (a_vec[i].idx < a_q.size()) ? 32'(a_q[a_vec[i].idx]) : 32'hDEADBEEF,
                  32'(a_vec[i].exp));
        a_en = 1'b0;

        // ---- C: start latency, checker values, frame limit and gap ----
        @(posedge clk); #1;
        c_en = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!c_wr && lat < 10);
        check("c_start_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 2000 && !(c_done_cnt >= 2 && !c_busy); i++) @(negedge clk);
        repeat (40) @(negedge clk);
        check("c_done_pulses", 32'(c_done_cnt), 32'd2);
        check("c_frame_starts", 32'(c_fs_cnt), 32'd2);
        check("c_frame_count", 32'(c_count), 32'd2);
        check("c_busy_after_limit", 32'(c_busy), 32'd0);
        check("c_word_total", 32'(c_q.size()), 32'd148);
        check("c_gap_ge_3", 32'(c_gap_min >= 3), 32'd1);
        for (int i = 0; i < 8; i++)
            check(c_vec[i].name, (c_vec[i].idx < c_q.size()) ? 32'(c_q[c_vec[i].idx]) : 32'hDEADBEEF,
                  32'(c_vec[i].exp));
        // Re-arm by toggling enable, then drop enable mid-frame: that frame must still finish.
        @(posedge clk); #1; c_en = 1'b0;
        repeat (2) @(posedge clk); #1; c_en = 1'b1;
        for (int i = 0; i < 50 && !c_wr; i++) @(negedge clk);
        @(posedge clk); #1; c_en = 1'b0;
        for (int i = 0; i < 500 && c_done_cnt < 3; i++) @(negedge clk);
        repeat (40) @(negedge clk);
        check("c_rearm_done", 32'(c_done_cnt), 32'd3);
        check("c_rearm_count", 32'(c_count), 32'd3);
        check("c_rearm_idle", 32'(c_busy), 32'd0);

        // ---- B: random backpressure and mode changes against the model ----
        b_sb_en = 1'b1;
        @(posedge clk); #1;
        b_en = 1'b1;
        for (int i = 0; i < 900; i++) begin
            @(posedge clk); #1;
            b_full = ($urandom_range(0, 1) == 1);
            // Frame 0 is bars; switching to solid mid-frame must only affect frame 1 (all FFE0).
            if (i == 15 && b_in_frame) b_mode = 2'd3;
            else if (b_in_frame && b_fc_model >= 2 && $urandom_range(0, 15) == 0)
                b_mode = 2'($urandom_range(0, 3));
        end
        b_full = 1'b0;
        check("b_no_wr_when_full", 32'(b_viol), 32'd0);
        check("b_frames_seen", 32'(b_fc_model >= 5), 32'd1);

        // ---- B: asynchronous reset in the middle of a row ----
        for (int i = 0; i < 300 && !(b_in_frame && b_exp.size() > 3 && b_exp.size() < 30); i++)
            @(negedge clk);
        @(posedge clk); #3;
        b_sb_en = 1'b0;
        b_rst_n = 1'b0;
        #1;
        check("b_rst_data",  32'(b_data),  32'h0);
        check("b_rst_wr",    32'(b_wr),    32'h0);
        check("b_rst_done",  32'(b_done),  32'h0);
        check("b_rst_count", 32'(b_count), 32'h0);
        check("b_rst_busy",  32'(b_busy),  32'h0);
        b_exp.delete();
        b_in_frame = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        b_mode = 2'd0;
        b_rst_n = 1'b1;
        for (int i = 0; i < 10 && !b_wr; i++) @(negedge clk);
        check("b_post_rst_word0", 32'(b_data), 32'h10000);
        check("b_post_rst_wr",    32'(b_wr),   32'h1);
        check("b_post_rst_count", 32'(b_count), 32'h0);
        b_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
